// File: rtl/ksa_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ksa_seq_pkg
// Brief   : Shared types and constants for the ksa_wide_seq multi-word adder.
// Revision: 1.0 - initial release
// ============================================================================
package ksa_seq_pkg;

    localparam int c_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Requester-index width; never narrower than one bit.
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_wide_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : ksa_wide_seq_if
// Brief   : Requester/response bundle for ksa_wide_seq. KSA_SEQ_SUB_EN adds
//           the per-requester req_sub bit.
// Revision: 1.0 - initial release
// ============================================================================
import ksa_seq_pkg::*;

interface ksa_wide_seq_if #(
    parameter int WORDS = 4,
    parameter int NREQ  = 2
);
    localparam int W   = c_WORD_W * WORDS;
    localparam int IDW = idw_f(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
`ifdef KSA_SEQ_SUB_EN
    logic [NREQ-1:0]   req_sub;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    modport master (
`ifdef KSA_SEQ_SUB_EN
        output req_sub,
`endif
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
`ifdef KSA_SEQ_SUB_EN
        input  req_sub,
`endif
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface
`default_nettype wire

// File: rtl/ksa32.sv
`default_nettype none
// ============================================================================
// Module  : ksa32
// Brief   : 32-bit Kogge-Stone adder core with carry-in and carry-out.
// Revision: 1.0 - initial release
// ============================================================================
module ksa32 (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_cin,
    output logic      [31:0] o_sum,
    output logic             o_cout
);

    // Position 0 carries cin as a generate term; bit k of the operands sits at k+1.
    logic [32:0] w_g;
    logic [32:0] w_p;
    logic [32:0] w_gn;
    logic [32:0] w_pn;

    always_comb begin
        w_g = {i_a & i_b, i_cin};
        w_p = {i_a ^ i_b, 1'b0};
        w_gn = w_g;
        w_pn = w_p;
        for (int l = 0; l < 6; l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = 0; i < 33; i++) begin
                if (i >= (1 << l)) begin
                    w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                    w_pn[i] = w_p[i] & w_p[i - (1 << l)];
                end
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        o_sum  = (i_a ^ i_b) ^ w_g[31:0];
        o_cout = w_g[32];
    end

endmodule
`default_nettype wire

// File: rtl/ksa_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : ksa_rr_arb
// Brief   : Combinational round-robin picker; search starts after i_last_grant.
// Revision: 1.0 - initial release
// ============================================================================
module ksa_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDW-1:0]  i_last_grant,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_grant_idx
);

    logic w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && i_req[(int'(i_last_grant) + k) % NREQ]) begin
                o_grant[(int'(i_last_grant) + k) % NREQ] = 1'b1;
                o_grant_idx = IDW'((int'(i_last_grant) + k) % NREQ);
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ksa_wide_seq.sv
`default_nettype none
// ============================================================================
// Module  : ksa_wide_seq
// Brief   : Multi-word add sequencer sharing one 32-bit Kogge-Stone slice among
//           NREQ round-robin requesters. KSA_SEQ_SUB_EN enables subtraction.
// Revision: 1.0 - initial release
// ============================================================================
import ksa_seq_pkg::*;

module ksa_wide_seq #(
    parameter int WORDS = 4,
    parameter int NREQ  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ksa_wide_seq_if.slave  bus
);

    localparam int W   = c_WORD_W * WORDS;
    localparam int IDW = idw_f(NREQ);
    localparam int IXW = $clog2(WORDS);

    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_RUN  = ST_RUN;
    localparam logic [1:0] c_ST_DONE = ST_DONE;

    logic [1:0]          r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic [IXW-1:0]      r_idx;
    logic                r_carry;
    logic                r_cout;
    logic [IDW-1:0]      r_id;
    logic [IDW-1:0]      r_last;

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_gidx;
    logic                w_idle;
    logic [c_WORD_W-1:0] w_b_word;
    logic                w_cin0;
    logic [c_WORD_W-1:0] w_s;
    logic                w_c;

    ksa_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx)
    );

`ifdef KSA_SEQ_SUB_EN
    logic r_sub;
    assign w_b_word = r_b[c_WORD_W-1:0] ^ {c_WORD_W{r_sub}};
    assign w_cin0   = bus.req_sub[w_gidx] | bus.req_cin[w_gidx];
`else
    assign w_b_word = r_b[c_WORD_W-1:0];
    assign w_cin0   = bus.req_cin[w_gidx];
`endif

    // Operands shift down one word per RUN cycle so the slice always sees word 0.
    ksa32 u_ksa (
        .i_a    (r_a[c_WORD_W-1:0]),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    assign w_idle        = (r_state == c_ST_IDLE);
    assign bus.req_ready = w_idle ? w_grant : '0;
    assign bus.rsp_valid = (r_state == c_ST_DONE);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;
    assign bus.busy      = !w_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_id    <= '0;
            r_last  <= IDW'(NREQ - 1);
`ifdef KSA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_grant) begin
                        r_a     <= bus.req_a[int'(w_gidx)*W +: W];
                        r_b     <= bus.req_b[int'(w_gidx)*W +: W];
                        r_idx   <= '0;
                        r_carry <= w_cin0;
                        r_last  <= w_gidx;
                        r_id    <= w_gidx;
`ifdef KSA_SEQ_SUB_EN
                        r_sub   <= bus.req_sub[w_gidx];
`endif
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_a     <= r_a >> c_WORD_W;
                    r_b     <= r_b >> c_WORD_W;
                    r_sum   <= {w_s, r_sum[W-1:c_WORD_W]};
                    r_carry <= w_c;
                    if (r_idx == IXW'(WORDS - 1)) begin
                        r_cout  <= w_c;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ksa_wide_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ksa_wide_seq
// Brief   : Scoreboard bench for ksa_wide_seq: directed corner cases plus
//           random traffic against a wide-integer reference model.
// Revision: 1.0 - initial release
// ============================================================================
import ksa_seq_pkg::*;

module tb_ksa_wide_seq;

    localparam int WORDS = 4;
    localparam int NREQ  = 2;
    localparam int W     = c_WORD_W * WORDS;
    localparam int IDW   = idw_f(NREQ);

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic           cout;
    } exp_t;

    logic clk;
    logic rst;
    ksa_wide_seq_if #(.WORDS(WORDS), .NREQ(NREQ)) bus ();

    ksa_wide_seq #(.WORDS(WORDS), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_chk  = 0;
    int              n_fail = 0;
    exp_t            q[$];
    logic            m_busy = 1'b0;
    int              m_last = NREQ - 1;
    int              m_cyc  = 0;
    int              m_acc_cyc = 0;
    logic [NREQ-1:0] m_acc_vec = '0;
    logic            rnd_rdy = 1'b0;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Reference: unsigned W-bit arithmetic; subtraction as A + ~B + 1.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic            exp_vld;
        int              g;
        logic            sub;
        logic [W:0]      r;
        exp_t            e;
        if (rst) begin
            q.delete();
            m_busy    = 1'b0;
            m_last    = NREQ - 1;
            m_acc_vec = '0;
        end else begin
            m_cyc++;
            exp_rdy = '0;
            g = -1;
            if (!m_busy) begin
                g = rr_pick(bus.req_valid, m_last);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", (W+1)'(bus.req_ready), (W+1)'(exp_rdy));
            chk("busy", (W+1)'(bus.busy), (W+1)'(m_busy));
            exp_vld = m_busy && ((m_cyc - m_acc_cyc) >= WORDS + 1);
            chk("rsp_valid", (W+1)'(bus.rsp_valid), (W+1)'(exp_vld));
            if (bus.rsp_valid && q.size() > 0) begin
                chk("rsp_id", (W+1)'(bus.rsp_id), (W+1)'(q[0].id));
                chk("rsp_sum", (W+1)'(bus.rsp_sum), (W+1)'(q[0].sum));
                chk("rsp_cout", (W+1)'(bus.rsp_cout), (W+1)'(q[0].cout));
            end
            if (bus.rsp_valid && bus.rsp_ready && exp_vld) begin
                void'(q.pop_front());
                m_busy = 1'b0;
            end
            m_acc_vec = exp_rdy;
            if (g >= 0) begin
                sub = 1'b0;
`ifdef KSA_SEQ_SUB_EN
                sub = bus.req_sub[g];
`endif
                r = ref_op(bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_cin[g], sub);
                e.id   = IDW'(g);
                e.sum  = r[W-1:0];
                e.cout = r[W];
                q.push_back(e);
                m_busy    = 1'b1;
                m_last    = g;
                m_acc_cyc = m_cyc;
            end
        end
    end

    // Advance one cycle; requesters drop valid once accepted.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~m_acc_vec;
        if (rnd_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        int n = 0;
        while (bus.req_valid[i] && n < 400) begin tick(); n++; end
        if (bus.req_valid[i]) begin
            n_fail++;
            $display("FAIL issue_timeout req=%0d actual=pending required=idle", i);
        end
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_cin[i]      = cin;
`ifdef KSA_SEQ_SUB_EN
        bus.req_sub[i]      = sub;
`else
        if (sub) $display("note: subtraction requested in add-only build");
`endif
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.req_valid != '0 || m_busy) && n < 400) begin tick(); n++; end
        if (bus.req_valid != '0 || m_busy) begin
            n_fail++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int k = 0; k < WORDS; k++) v[k*c_WORD_W +: c_WORD_W] = $urandom;
        case ($urandom_range(0, 5))
            0: v = '1;
            1: v = '0;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
`ifdef KSA_SEQ_SUB_EN
        bus.req_sub   = '0;
`endif
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", (W+1)'(bus.req_ready), '0);
        chk("rst_rsp_valid", (W+1)'(bus.rsp_valid), '0);
        chk("rst_rsp_id", (W+1)'(bus.rsp_id), '0);
        chk("rst_rsp_sum", (W+1)'(bus.rsp_sum), '0);
        chk("rst_rsp_cout", (W+1)'(bus.rsp_cout), '0);
        chk("rst_busy", (W+1)'(bus.busy), '0);
        rst = 1'b0;

        // Carry across word 0 -> word 1, then full ripple through all words
        issue(0, W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0);
        drain();
        issue(0, '1, '0, 1'b1, 1'b0);
        drain();

        // Simultaneous requests, twice
        issue(0, rnd_w(), rnd_w(), 1'b0, 1'b0);
        issue(1, rnd_w(), rnd_w(), 1'b1, 1'b0);
        drain();
        issue(1, rnd_w(), rnd_w(), 1'b0, 1'b0);
        issue(0, rnd_w(), rnd_w(), 1'b1, 1'b0);
        drain();

        // Back-pressure: DONE held with a competing request pending
        bus.rsp_ready = 1'b0;
        issue(1, rnd_w(), rnd_w(), 1'b1, 1'b0);
        repeat (3) tick();
        issue(0, rnd_w(), rnd_w(), 1'b0, 1'b0);
        repeat (13) tick();
        bus.rsp_ready = 1'b1;
        drain();

        // Reset during the second RUN cycle
        issue(0, rnd_w(), rnd_w(), 1'b0, 1'b0);
        n = 0;
        while (bus.req_valid[0] && n < 50) begin tick(); n++; end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(1, rnd_w(), rnd_w(), 1'b0, 1'b0);
        issue(0, rnd_w(), rnd_w(), 1'b1, 1'b0);
        drain();

`ifdef KSA_SEQ_SUB_EN
        issue(0, W'(5), W'(7), 1'b0, 1'b1);
        drain();
        issue(1, W'(7), W'(5), 1'b0, 1'b1);
        drain();
`endif

        // Random traffic with random response back-pressure
        rnd_rdy = 1'b1;
        for (int t = 0; t < 60; t++) begin
            logic s;
            s = 1'b0;
`ifdef KSA_SEQ_SUB_EN
            s = 1'($urandom_range(0, 1));
`endif
            issue($urandom_range(0, NREQ - 1), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)), s);
            repeat ($urandom_range(0, 6)) tick();
        end
        rnd_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
